// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Operand stack for the stack-machine datapath. Executes push/pop/tos
// strobes from the multicycle controller against a LIFO register file and
// returns the top of stack through a registered output to the operand latches.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - asynchronous, active-low reset
//   push     - push strobe (din written on top)
//   pop      - pop strobe (top discarded)
//   tos      - capture current (pre-edge) top into dout
//   din      - data to push
//   err_clr  - synchronous clear of the sticky ovf/unf flags
//   dout     - registered top-of-stack value
//   count    - current occupancy, 0..DEPTH
//   empty    - count == 0
//   full     - count == DEPTH
//   ovf      - sticky: push attempted while full
//   unf      - sticky: pop or tos attempted while empty
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] topIdx;
    logic [AW-1:0] wrIdx;
    logic          doPush;
    logic          doPop;
    logic          doReplace;
    logic          setOvf;
    logic          setUnf;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // topIdx is only used when the stack is non-empty and wrIdx only when it
    // is not full, so both truncations stay inside 0..DEPTH-1.
    assign topIdx = AW'(count - CW'(1));
    assign wrIdx  = AW'(count);

    assign doPush    = push & ~pop & ~full;
    assign doPop     = pop & ~push & ~empty;
    assign doReplace = push & pop & ~empty;

    // A pop on an empty stack (with or without push) and a tos on an empty
    // stack both flag underflow; push-only on a full stack flags overflow.
    assign setOvf = push & ~pop & full;
    assign setUnf = empty & (pop | tos);

    // Storage is deliberately not reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrIdx] <= din;
        end else if (doReplace) begin
            mem[topIdx] <= din;
        end
    end

    // Occupancy, output register and sticky flags. Every decision uses the
    // pre-edge count and mem, so tos+pop returns the value being popped and
    // tos+push returns the old top rather than din.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (doPush) begin
                count <= count + CW'(1);
            end else if (doPop) begin
                count <= count - CW'(1);
            end

            if (tos) begin
                dout <= empty ? '0 : mem[topIdx];
            end

            // Setting conditions take priority over err_clr.
            if (setOvf) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end

            if (setUnf) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit (WIDTH=8, DEPTH=16). Expected dout
// values are queued when a tos strobe is driven and popped one edge later
// when the registered output is sampled.
// ---------------------------------------------------------------------------
module tb_stack_unit;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       tos;
    logic [7:0] din;
    logic       err_clr;
    logic [7:0] dout;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbq [$];
    logic [7:0] expData;

    stack_unit #(.WIDTH(8), .DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .din     (din),
        .err_clr (err_clr),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of strobes, sample 1 time unit after the active edge.
    task automatic step(input logic p, input logic po, input logic t,
                        input logic [7:0] d, input logic ec);
        push = p; pop = po; tos = t; din = d; err_clr = ec;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #4;
        rst = 1'b1;
        #1;
    endtask

    task automatic check_dout(input string name);
        expData = sbq.pop_front();
        checks++;
        if (dout !== expData) begin
            errors++;
            $display("[TB] FAIL %s: dout=%h expected %h", name, dout, expData);
        end
    endtask

    task automatic check_count(input string name, input logic [4:0] exp);
        checks++;
        if (count !== exp) begin
            errors++;
            $display("[TB] FAIL %s: count=%0d expected %0d", name, count, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        check_count("reset_count", 5'd0);
        check_bit("reset_empty", empty, 1'b1);
        check_bit("reset_full", full, 1'b0);
        check_bit("reset_ovf", ovf, 1'b0);
        check_bit("reset_unf", unf, 1'b0);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dout: dout=%h expected 00", dout);
        end
    endtask

    task automatic test_push_tos();
        step(1, 0, 0, 8'h11, 0);
        step(1, 0, 0, 8'h22, 0);
        step(1, 0, 0, 8'h33, 0);
        sbq.push_back(8'h33);
        step(0, 0, 1, 8'h00, 0);
        check_dout("push3_tos");
        check_count("push3_count", 5'd3);
        check_bit("push3_empty", empty, 1'b0);
        check_bit("push3_full", full, 1'b0);
    endtask

    task automatic test_tos_pop();
        sbq.push_back(8'h33);
        step(0, 1, 1, 8'h00, 0);
        check_dout("tospop_dout");
        check_count("tospop_count", 5'd2);
        sbq.push_back(8'h22);
        step(0, 0, 1, 8'h00, 0);
        check_dout("tospop_next_top");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'(i), 0);
        end
        check_bit("full_flag", full, 1'b1);
        check_count("full_count", 5'd16);
        check_bit("full_no_ovf_yet", ovf, 1'b0);
        step(1, 0, 0, 8'hAA, 0);
        check_bit("ovf_set", ovf, 1'b1);
        check_count("ovf_count_held", 5'd16);
        sbq.push_back(8'h0F);
        step(0, 0, 1, 8'h00, 0);
        check_dout("ovf_top_unchanged");
        // Overflow condition in the same cycle as err_clr keeps ovf set.
        step(1, 0, 0, 8'hBB, 1);
        check_bit("ovf_set_beats_clr", ovf, 1'b1);
        step(0, 0, 0, 8'h00, 1);
        check_bit("ovf_cleared", ovf, 1'b0);
        // Drain one entry; full must drop and the next top must be 14.
        sbq.push_back(8'h0F);
        step(0, 1, 1, 8'h00, 0);
        check_dout("drain_popped");
        check_bit("drain_full", full, 1'b0);
        check_count("drain_count", 5'd15);
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 1, 0, 8'h00, 0);
        check_bit("unf_pop_empty", unf, 1'b1);
        check_count("unf_pop_count", 5'd0);
        sbq.push_back(8'h00);
        step(0, 0, 1, 8'h00, 0);
        check_dout("unf_tos_dout");
        check_bit("unf_tos_sticky", unf, 1'b1);
        step(1, 1, 0, 8'h5A, 0);
        check_count("unf_pushpop_count", 5'd0);
        check_bit("unf_pushpop_flag", unf, 1'b1);
        step(0, 0, 0, 8'h00, 1);
        check_bit("unf_cleared", unf, 1'b0);
        // tos-only on empty must set unf even with err_clr asserted.
        step(0, 0, 1, 8'h00, 1);
        check_bit("unf_tos_beats_clr", unf, 1'b1);
        check_bit("unf_ovf_untouched", ovf, 1'b0);
    endtask

    task automatic test_replace();
        do_reset();
        step(1, 0, 0, 8'h05, 0);
        step(1, 0, 0, 8'h07, 0);
        step(1, 1, 0, 8'h09, 0);
        check_count("replace_count", 5'd2);
        sbq.push_back(8'h09);
        step(0, 0, 1, 8'h00, 0);
        check_dout("replace_top");
        step(0, 1, 0, 8'h00, 0);
        check_count("replace_pop_count", 5'd1);
        sbq.push_back(8'h05);
        step(0, 0, 1, 8'h00, 0);
        check_dout("replace_below");
    endtask

    task automatic test_back_to_back();
        // Stack holds [05]; tos+push returns the old top, not din.
        sbq.push_back(8'h05);
        step(1, 0, 1, 8'h44, 0);
        check_dout("tospush_old_top");
        check_count("tospush_count", 5'd2);
        sbq.push_back(8'h44);
        step(1, 0, 1, 8'h66, 0);
        check_dout("b2b_top1");
        sbq.push_back(8'h66);
        step(0, 1, 1, 8'h00, 0);
        check_dout("b2b_top2");
        sbq.push_back(8'h44);
        step(0, 1, 1, 8'h00, 0);
        check_dout("b2b_top3");
        check_count("b2b_count", 5'd1);
        check_bit("b2b_no_unf", unf, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 1, 0, 8'h00, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 8'(8'h20 + i), 0);
        end
        sbq.push_back(8'h24);
        step(0, 0, 1, 8'h00, 0);
        check_dout("arst_pre_top");
        // Assert reset between edges with push held high.
        push = 1'b1;
        din  = 8'h55;
        #2;
        rst = 1'b0;
        #1;
        check_count("arst_count", 5'd0);
        check_bit("arst_unf", unf, 1'b0);
        check_bit("arst_ovf", ovf, 1'b0);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL arst_dout: dout=%h expected 00", dout);
        end
        @(posedge clk);
        #1;
        check_count("arst_held_count", 5'd0);
        push = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back(8'h00);
        step(0, 0, 1, 8'h00, 0);
        check_dout("arst_post_tos");
        check_bit("arst_post_unf", unf, 1'b1);
        check_count("arst_post_count", 5'd0);
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0;
        din = 8'h00; err_clr = 1'b0;
        #12;
        rst = 1'b1;
        #1;
        test_reset();
        test_push_tos();
        test_tos_pop();
        test_full();
        test_underflow();
        test_replace();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
